// File: rtl/whack_game_ctrl.sv
// rtl/whack_game_ctrl.sv - whack-a-mole round sequencer; optional WHACK_WRONG_PENALTY_EN makes wrong keys cost a life
module whack_game_ctrl #(
   parameter int MOLE_CYCLES = 50_000_000,
   parameter int MIN_CYCLES  = 12_500_000,
   parameter int STEP_CYCLES = 2_500_000,
   parameter int GAP_CYCLES  = 10_000_000,
   parameter int LIVES       = 3,
   parameter int CNT_W       = 26
) (
   input  logic       CLOCK_50,
   input  logic       RESET,
   input  logic [3:0] KEY,
   input  logic       START,
   output logic [3:0] LEDR,
   output logic [7:0] SCORE_BCD,
   output logic [2:0] LIVES_LEFT,
   output logic       GAME_OVER,
   output logic       HIT,
   output logic       MISS
);
   typedef enum logic [1:0] {S_IDLE, S_GAP, S_UP, S_OVER} state_t;

   localparam logic [CNT_W-1:0] MOLE_W    = CNT_W'(MOLE_CYCLES);
   localparam logic [CNT_W-1:0] MIN_W     = CNT_W'(MIN_CYCLES);
   localparam logic [CNT_W-1:0] STEP_W    = CNT_W'(STEP_CYCLES);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W:0]   FLOOR_SUM = (CNT_W+1)'(MIN_CYCLES + STEP_CYCLES);
   localparam logic [2:0]       LIVES_W   = 3'(LIVES);

   state_t           state, state_n;
   logic [3:0]       key_s1, key_s2, key_prev;
   logic [3:0]       lfsr, lfsr_n, lfsr_step;
   logic [3:0]       leds, leds_n;
   logic [7:0]       score, score_n, score_inc;
   logic [2:0]       lives, lives_n;
   logic [CNT_W-1:0] window, window_n, win_shrunk;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             hit_r, hit_n, miss_r, miss_n;
   logic [3:0]       press;
   logic             hit_now, wrong_now, timeout;

   assign LEDR       = leds;
   assign SCORE_BCD  = score;
   assign LIVES_LEFT = lives;
   assign GAME_OVER  = (state == S_OVER);
   assign HIT        = hit_r;
   assign MISS       = miss_r;

   // Judging helpers: key edges, next LFSR value, saturating BCD and floored window
   always_comb begin
      press     = key_s2 & ~key_prev;
      lfsr_step = {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      hit_now   = |(press & leds);
`ifdef WHACK_WRONG_PENALTY_EN
      wrong_now = (press != 4'b0000) && !hit_now;
`else
      wrong_now = 1'b0;
`endif
      timeout   = (cnt == window - CNT_W'(1));
      if (score == 8'h99)
         score_inc = score;
      else if (score[3:0] == 4'd9)
         score_inc = {score[7:4] + 4'd1, 4'd0};
      else
         score_inc = {score[7:4], score[3:0] + 4'd1};
      // compare in one extra bit so a small window never wraps below the floor
      if ({1'b0, window} < FLOOR_SUM)
         win_shrunk = MIN_W;
      else
         win_shrunk = window - STEP_W;
   end

   // Round flow: next state and next values of every game register
   always_comb begin
      state_n  = state;
      leds_n   = leds;
      score_n  = score;
      lives_n  = lives;
      window_n = window;
      cnt_n    = cnt;
      lfsr_n   = lfsr;
      hit_n    = 1'b0;
      miss_n   = 1'b0;
      case (state)
         S_IDLE, S_OVER: begin
            leds_n = 4'b0000;
            if (START) begin
               score_n  = 8'h00;
               lives_n  = LIVES_W;
               window_n = MOLE_W;
               cnt_n    = '0;
               state_n  = S_GAP;
            end
         end
         S_GAP: begin
            leds_n = 4'b0000;
            if (cnt == GAP_LAST) begin
               lfsr_n  = lfsr_step;
               leds_n  = 4'b0001 << lfsr_step[1:0];
               cnt_n   = '0;
               state_n = S_UP;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         S_UP: begin
            cnt_n = cnt + CNT_W'(1);
            if (hit_now) begin
               hit_n    = 1'b1;
               leds_n   = 4'b0000;
               score_n  = score_inc;
               window_n = win_shrunk;
               cnt_n    = '0;
               state_n  = S_GAP;
            end else if (timeout || wrong_now) begin
               miss_n  = 1'b1;
               leds_n  = 4'b0000;
               lives_n = lives - 3'd1;
               cnt_n   = '0;
               state_n = (lives == 3'd1) ? S_OVER : S_GAP;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Registers: key synchronizer chain plus all game state
   always_ff @(posedge CLOCK_50 or posedge RESET) begin
      if (RESET) begin
         state    <= S_IDLE;
         key_s1   <= 4'b0000;
         key_s2   <= 4'b0000;
         key_prev <= 4'b0000;
         lfsr     <= 4'b0001;
         leds     <= 4'b0000;
         score    <= 8'h00;
         lives    <= 3'd0;
         window   <= MOLE_W;
         cnt      <= '0;
         hit_r    <= 1'b0;
         miss_r   <= 1'b0;
      end else begin
         state    <= state_n;
         key_s1   <= ~KEY;
         key_s2   <= key_s1;
         key_prev <= key_s2;
         lfsr     <= lfsr_n;
         leds     <= leds_n;
         score    <= score_n;
         lives    <= lives_n;
         window   <= window_n;
         cnt      <= cnt_n;
         hit_r    <= hit_n;
         miss_r   <= miss_n;
      end
   end
endmodule

// File: tb/tb_whack_game_ctrl.sv
// tb/tb_whack_game_ctrl.sv - directed bench for whack_game_ctrl
`timescale 1ns/1ps
module tb_whack_game_ctrl;
   logic       CLOCK_50 = 1'b0;
   logic       RESET;
   logic [3:0] KEY;
   logic       START;
   logic [3:0] LEDR;
   logic [7:0] SCORE_BCD;
   logic [2:0] LIVES_LEFT;
   logic       GAME_OVER;
   logic       HIT;
   logic       MISS;

   int vectors     = 0;
   int miscompares = 0;
   int spawns      = 0;
   int hole;

   // hole sequence from reset, worked out by hand from the LFSR recurrence
   logic [1:0] hole_seq [0:14] = '{2'd2, 2'd0, 2'd1, 2'd3, 2'd2, 2'd1, 2'd2, 2'd1,
                                  2'd3, 2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1};

   always #5 CLOCK_50 = ~CLOCK_50;

   whack_game_ctrl #(
      .MOLE_CYCLES(20), .MIN_CYCLES(8), .STEP_CYCLES(4), .GAP_CYCLES(5), .LIVES(3), .CNT_W(26)
   ) dut (
      .CLOCK_50(CLOCK_50), .RESET(RESET), .KEY(KEY), .START(START), .LEDR(LEDR),
      .SCORE_BCD(SCORE_BCD), .LIVES_LEFT(LIVES_LEFT), .GAME_OVER(GAME_OVER),
      .HIT(HIT), .MISS(MISS)
   );

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] bcd(input int n);
      int m;
      m = (n > 99) ? 99 : n;
      return 8'(((m / 10) * 16) + (m % 10));
   endfunction

   task automatic wait_spawn(input string tag, input int exp_gap, output int h);
      int n = 0;
      h = int'(hole_seq[spawns % 15]);
      while (LEDR == 4'b0000 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, " gap"}, 8'(n), 8'(exp_gap));
      chk({tag, " hole"}, 8'(LEDR), 8'(4'b0001 << h));
      spawns++;
   endtask

   task automatic wait_timeout(input string tag, input int w);
      int n = 0;
      logic any_hit = 1'b0;
      while (LEDR != 4'b0000 && n < 60) begin
         tick();
         n++;
         if (HIT) any_hit = 1'b1;
      end
      chk({tag, " lit"}, 8'(n), 8'(w));
      chk({tag, " miss"}, 8'(MISS), 8'd1);
      chk({tag, " nohit"}, 8'(any_hit), 8'd0);
   endtask

   task automatic hit_at(input string tag, input int h, input int d);
      for (int i = 0; i < d - 3; i++) tick();
      KEY[h] = 1'b0;
      tick();
      tick();
      chk({tag, " still lit"}, 8'(LEDR), 8'(4'b0001 << h));
      tick();
      chk({tag, " hit"}, 8'(HIT), 8'd1);
      chk({tag, " miss"}, 8'(MISS), 8'd0);
      chk({tag, " dark"}, 8'(LEDR), 8'd0);
      KEY = 4'hF;
   endtask

   initial begin
      KEY   = 4'hF;
      START = 1'b0;
      RESET = 1'b1;
      tick();
      tick();
      chk("rst ledr", 8'(LEDR), 8'd0);
      chk("rst score", SCORE_BCD, 8'h00);
      chk("rst lives", 8'(LIVES_LEFT), 8'd0);
      chk("rst over", 8'(GAME_OVER), 8'd0);
      chk("rst hit", 8'(HIT), 8'd0);
      chk("rst miss", 8'(MISS), 8'd0);
      RESET = 1'b0;
      tick();
      chk("idle ledr", 8'(LEDR), 8'd0);

      // first mole on hole 2, hit it, then window shrinks to 16
      START = 1'b1;
      tick();
      START = 1'b0;
      chk("t1 lives", 8'(LIVES_LEFT), 8'd3);
      chk("t1 ledr gap", 8'(LEDR), 8'd0);
      wait_spawn("t1 m1", 5, hole);
      chk("t1 m1 led", 8'(LEDR), 8'h04);
      hit_at("t1", hole, 3);
      chk("t1 score", SCORE_BCD, 8'h01);
      tick();
      chk("t1 hit pulse", 8'(HIT), 8'd0);
      wait_spawn("t1 m2", 4, hole);
      chk("t1 m2 led", 8'(LEDR), 8'h01);
      wait_timeout("t1 win16", 16);
      chk("t1 lives2", 8'(LIVES_LEFT), 8'd2);

      // never press: three 20-cycle moles then game over
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      spawns = 0;
      START = 1'b1;
      tick();
      START = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_spawn("t2", 5, hole);
         wait_timeout("t2 win20", 20);
         chk("t2 lives", 8'(LIVES_LEFT), 8'(2 - k));
      end
      chk("t2 over", 8'(GAME_OVER), 8'd1);
      chk("t2 ledr", 8'(LEDR), 8'd0);
      for (int i = 0; i < 8; i++) tick();
      chk("t2 over held", 8'(GAME_OVER), 8'd1);
      chk("t2 no spawn", 8'(LEDR), 8'd0);

      // restart from OVER, hit on the last lit cycle of windows 20,16,12,8
      START = 1'b1;
      tick();
      START = 1'b0;
      chk("t3 over clr", 8'(GAME_OVER), 8'd0);
      chk("t3 lives", 8'(LIVES_LEFT), 8'd3);
      chk("t3 score", SCORE_BCD, 8'h00);
      wait_spawn("t3 a", 5, hole);
      hit_at("t3 w20", hole, 20);
      wait_spawn("t3 b", 5, hole);
      hit_at("t3 w16", hole, 16);
      wait_spawn("t3 c", 5, hole);
      hit_at("t3 w12", hole, 12);
      wait_spawn("t3 d", 5, hole);
      hit_at("t3 w8", hole, 8);
      chk("t3 score4", SCORE_BCD, 8'h04);
      wait_spawn("t3 e", 5, hole);
      wait_timeout("t3 floor8", 8);
      chk("t3 lives", 8'(LIVES_LEFT), 8'd2);

      // score up to 99 and one past it
      for (int n = 5; n <= 100; n++) begin
         wait_spawn("t4", 5, hole);
         hit_at("t4", hole, 3);
         chk("t4 score", SCORE_BCD, bcd(n));
         if (n == 10) chk("t4 carry", SCORE_BCD, 8'h10);
      end
      chk("t4 sat", SCORE_BCD, 8'h99);

      // key pressed in GAP and held across spawn, START ignored in GAP
      hole = int'(hole_seq[spawns % 15]);
      KEY[hole] = 1'b0;
      START = 1'b1;
      tick();
      START = 1'b0;
      chk("t5 start ign", 8'(LIVES_LEFT), 8'd2);
      wait_spawn("t5 held", 4, hole);
      wait_timeout("t5 held", 8);
      chk("t5 lives", 8'(LIVES_LEFT), 8'd1);
      KEY = 4'hF;

      // asynchronous reset while a mole is up
      wait_spawn("t5 r", 5, hole);
      tick();
      tick();
      RESET = 1'b1;
      #1;
      chk("t5 rst ledr", 8'(LEDR), 8'd0);
      chk("t5 rst lives", 8'(LIVES_LEFT), 8'd0);
      chk("t5 rst score", SCORE_BCD, 8'h00);
      tick();
      RESET = 1'b0;
      spawns = 0;
      for (int i = 0; i < 10; i++) tick();
      chk("t5 idle ledr", 8'(LEDR), 8'd0);
      chk("t5 idle over", 8'(GAME_OVER), 8'd0);

      // wrong key while hole 2 is lit
      START = 1'b1;
      tick();
      START = 1'b0;
      wait_spawn("t6", 5, hole);
      KEY[0] = 1'b0;
      tick();
      tick();
      tick();
`ifdef WHACK_WRONG_PENALTY_EN
      chk("t6 miss", 8'(MISS), 8'd1);
      chk("t6 ledr", 8'(LEDR), 8'd0);
      chk("t6 lives", 8'(LIVES_LEFT), 8'd2);
`else
      chk("t6 miss", 8'(MISS), 8'd0);
      chk("t6 ledr", 8'(LEDR), 8'h04);
      chk("t6 lives", 8'(LIVES_LEFT), 8'd3);
      tick();
      chk("t6 ledr2", 8'(LEDR), 8'h04);
`endif
      KEY = 4'hF;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
